// File: rtl/axis_cpu_hazard_scoreboard.sv
// Hazard scoreboard: counts in-flight A/X/imm writes between decode and
// writeback, gates issue on counter overflow, and clears on mispredict.
module axis_cpu_hazard_scoreboard #(
    parameter int CNT_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           issue_instr,
    input  logic                 issue_vld,
    input  logic                 issue_rdy_in,
    output logic                 issue_rdy,
    input  logic                 retire_A,
    input  logic                 retire_X,
    input  logic                 retire_imm,
    input  logic                 flush,
    output logic                 pending_A,
    output logic                 pending_X,
    output logic                 pending_imm,
    output logic [CNT_WIDTH-1:0] cnt_A,
    output logic [CNT_WIDTH-1:0] cnt_X,
    output logic [CNT_WIDTH-1:0] cnt_imm,
    output logic                 err_underflow
);

    // Opcode fields (mirrors axis_cpu_defs.vh)
    localparam logic [2:0] OP_LD      = 3'b000;
    localparam logic [2:0] OP_ST      = 3'b001;
    localparam logic [2:0] OP_LDX     = 3'b010;
    localparam logic [2:0] OP_STX     = 3'b011;
    localparam logic [2:0] OP_ALU     = 3'b100;
    localparam logic [2:0] OP_JMP     = 3'b101;
    localparam logic [3:0] OP_TXA     = 4'b1100;
    localparam logic [3:0] OP_TAX     = 4'b1101;
    localparam logic [3:0] OP_SET_IMM = 4'b1110;

    localparam logic [CNT_WIDTH-1:0] MAX = {CNT_WIDTH{1'b1}};

    // Index 0 = A, 1 = X, 2 = imm
    logic [2:0]           wr;
    logic [2:0]           ret;
    logic [2:0]           at_max;
    logic [2:0]           at_zero;
    logic [2:0]           block;
    logic [2:0]           inc;
    logic                 fire;
    logic [CNT_WIDTH-1:0] cnt_q [3];
    logic                 err_q;

    // Destination decode of the instruction leaving decode
    always_comb begin
        wr    = '0;
        wr[0] = (issue_instr[7:5] == OP_LD) ||
                (issue_instr[7:5] == OP_ALU) ||
                (issue_instr[7:4] == OP_TXA);
        wr[1] = (issue_instr[7:5] == OP_LDX) ||
                (issue_instr[7:4] == OP_TAX);
        wr[2] = (issue_instr[7:4] == OP_SET_IMM);
    end

    assign ret = {retire_imm, retire_X, retire_A};

    // Overflow backpressure; a same-cycle retire frees the slot
    always_comb begin
        at_max  = '0;
        at_zero = '0;
        for (int i = 0; i < 3; i++) begin
            at_max[i]  = (cnt_q[i] == MAX);
            at_zero[i] = (cnt_q[i] == '0);
        end
    end

    assign block     = wr & at_max & ~ret;
    assign issue_rdy = issue_rdy_in && !(|block);
    assign fire      = issue_vld && issue_rdy && !flush && !rst;
    assign inc       = {3{fire}} & wr;

    // Counter and sticky-error update
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
            err_q <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (inc[i] && !ret[i]) begin
                    cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
                end else if (ret[i] && !inc[i] && !at_zero[i]) begin
                    cnt_q[i] <= cnt_q[i] - CNT_WIDTH'(1);
                end
            end
            if (|(ret & ~inc & at_zero)) err_q <= 1'b1;
        end
    end

    assign cnt_A         = cnt_q[0];
    assign cnt_X         = cnt_q[1];
    assign cnt_imm       = cnt_q[2];
    assign pending_A     = !at_zero[0];
    assign pending_X     = !at_zero[1];
    assign pending_imm   = !at_zero[2];
    assign err_underflow = err_q;

endmodule

// File: doc/axis_cpu_hazard_scoreboard.md
Name: axis_cpu_hazard_scoreboard

Overview:
- Tracks in-flight register writes (A, X, imm) between the decode stage's output handshake and writeback.
- Drives the decode stage's stage2_writes_A / stage2_writes_X / stage2_writes_imm stall inputs.
- Applies issue backpressure when a per-register in-flight counter would overflow.
- Clears all tracking on a branch-mispredict flush.

Parameters:
- CNT_WIDTH, 2, width of each per-register in-flight counter. MAX = 2^CNT_WIDTH-1 outstanding writes per register.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- issue_instr  input  8  instruction leaving decode (decode stage instr_out).
- issue_vld  input  1  decode output valid.
- issue_rdy_in  input  1  downstream ready seen by decode.
- issue_rdy  output  1  issue_rdy_in gated by overflow check; feeds decode's next_rdy.
- retire_A  input  1  one-cycle pulse: an A write has completed.
- retire_X  input  1  one-cycle pulse: an X write has completed.
- retire_imm  input  1  one-cycle pulse: an imm write has completed.
- flush  input  1  branch_mispredict.
- pending_A  output  1  A write in flight (to stage2_writes_A).
- pending_X  output  1  X write in flight (to stage2_writes_X).
- pending_imm  output  1  imm write in flight (to stage2_writes_imm).
- cnt_A  output  CNT_WIDTH  in-flight count for A (debug).
- cnt_X  output  CNT_WIDTH  in-flight count for X (debug).
- cnt_imm  output  CNT_WIDTH  in-flight count for imm (debug).
- err_underflow  output  1  sticky: a retire arrived with count 0.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. On rst, all counters = 0, all pending_* = 0, err_underflow = 0.
- Decode, combinational on issue_instr; opcode fields from axis_cpu_defs.vh:
  - wA = [7:5] is LD or ALU, or [7:4] is TXA.
  - wX = [7:5] is LDX, or [7:4] is TAX.
  - wI = [7:4] is SET_IMM.
  - ST, STX and JMP write nothing.
- Overflow check, combinational:
  - block_R = wR && cnt_R==MAX && !retire_R, for R in {A, X, imm}.
  - issue_rdy = issue_rdy_in && !(block_A || block_X || block_imm).
  - A retire in the same cycle frees the slot.
- Issue event: fire = issue_vld && issue_rdy && !flush && !rst.
- Per-register update each cycle, for R in {A, X, imm}:
  - inc = fire && wR; dec = retire_R && !flush.
  - inc && !dec: cnt+1. Never exceeds MAX, guaranteed by issue_rdy.
  - dec && !inc: cnt-1 if cnt>0. If cnt==0, cnt stays 0 and err_underflow sets.
  - inc && dec: cnt unchanged. This holds even at 0 and at MAX.
- Flush: counters clear to 0 on the next edge. Issue and retires in the flush cycle are ignored, including underflow detection. err_underflow is not cleared by flush, only by rst.
- Flush contract: flush asserts only once all writes older than the mispredicted branch have retired. Every counted write is therefore squashed.
- pending_R = (cnt_R != 0). It comes from registered state only, with no combinational path from issue inputs.
- Latency: a fire at edge n gives pending high after edge n. A retire at edge n with count 1 gives pending low after edge n. Decode therefore sees the hazard one cycle after issue.
- Same-cycle simultaneous events across different registers are independent.
- rst asserted mid-operation overrides everything: counters zero, error clear, and issue_rdy still follows the combinational rule.

Test Plan:
- Reset then idle: all cnt=0, pending_*=0, err_underflow=0. issue_rdy==issue_rdy_in.
- Issue ALU instruction (vld=rdy_in=1) -> cnt_A=1 and pending_A=1 next cycle, pending_X=0. retire_A pulse -> cnt_A=0, pending_A=0 the following cycle.
- Issue LDX four times with no retire (CNT_WIDTH=2):
  - cnt_X goes 1,2,3.
  - 4th cycle issue_rdy=0 and cnt_X stays 3.
  - Same cycle with retire_X=1 -> issue_rdy=1 and cnt_X stays 3.
- Issue TAX with retire_X in the same cycle at cnt_X=0 -> cnt_X stays 0, err_underflow stays 0. Issue ST -> no counter changes.
- cnt_A=2, cnt_imm=1, assert flush with issue of SET_IMM and retire_A -> all counters 0 next cycle, err_underflow unchanged.
- retire_imm with cnt_imm=0 -> err_underflow=1, held through flush, cleared only by rst.
